// File: rtl/toggle_decoder.sv
// Receiver for a toggle-signalling link: synchronises the remote T flip-flop level,
// emits one pulse per accepted transition, counts events and measures inter-event periods.
module toggle_decoder #(
    parameter int unsigned CW = 4,
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          t_in,
    output logic          pulse,
    output logic [CW-1:0] count,
    output logic          count_wrap,
    output logic [PW-1:0] period,
    output logic          period_valid,
    input  logic          period_ack,
    output logic          overrun
);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    localparam logic [CW-1:0] COUNT_MAX  = '1;
    localparam logic [PW-1:0] PERIOD_MAX = '1;
    localparam logic [PW-1:0] PERIOD_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic          s1;
    logic          s2;
    logic          s3;
    state_t        state;
    logic [PW-1:0] cycles;
    logic          accepted;
    logic          emit;

    always_comb begin
        accepted = (s2 ^ s3) & enable;
        emit     = accepted && (state == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            pulse        <= 1'b0;
            count        <= '0;
            count_wrap   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            cycles       <= '0;
            state        <= IDLE;
        end else begin
            // Synchroniser runs even while disabled so re-enabling sees no stale edge.
            s1    <= t_in;
            s2    <= s1;
            s3    <= s2;
            pulse <= accepted;

            if (accepted) begin
                count <= count + 1'b1;
                if (count == COUNT_MAX)
                    count_wrap <= 1'b1;
            end

            if (!enable) begin
                state  <= IDLE;
                cycles <= '0;
            end else if (accepted) begin
                state  <= MEASURE;
                cycles <= PERIOD_ONE;
            end else if (state == MEASURE && cycles != PERIOD_MAX) begin
                cycles <= cycles + 1'b1;
            end

            // An ack on the emit edge frees the slot, so the new value replaces the old one.
            if (emit) begin
                if (!period_valid || period_ack) begin
                    period       <= cycles;
                    period_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (period_valid && period_ack) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed, table-driven bench for toggle_decoder with hand-written sequences
// for simultaneous ack/emit, single-cycle ack and mid-measurement reset.
module tb_toggle_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       t_in;
    logic       pulse;
    logic [3:0] count;
    logic       count_wrap;
    logic [7:0] period;
    logic       period_valid;
    logic       period_ack;
    logic       overrun;

    int total  = 0;
    int passed = 0;

    toggle_decoder #(.CW(4), .PW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .t_in         (t_in),
        .pulse        (pulse),
        .count        (count),
        .count_wrap   (count_wrap),
        .period       (period),
        .period_valid (period_valid),
        .period_ack   (period_ack),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ack;
        logic       tog;
        int         gap;
        logic       exp_pulse;
        logic [3:0] exp_count;
        logic       exp_wrap;
        logic [7:0] exp_period;
        logic       exp_pv;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [0:22];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Each record: set inputs (optionally toggle) at a falling edge, run `gap` cycles,
    // check outputs 3 cycles after the toggle and that the pulse is gone one cycle later.
    task automatic run_vecs(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            enable     = vecs[v].en;
            period_ack = vecs[v].ack;
            if (vecs[v].tog) t_in = ~t_in;
            for (int i = 0; i < vecs[v].gap; i++) begin
                step();
                if (i == 2) begin
                    check($sformatf("v%0d pulse", v), int'(pulse), int'(vecs[v].exp_pulse));
                    check($sformatf("v%0d count", v), int'(count), int'(vecs[v].exp_count));
                    check($sformatf("v%0d count_wrap", v), int'(count_wrap), int'(vecs[v].exp_wrap));
                    check($sformatf("v%0d period", v), int'(period), int'(vecs[v].exp_period));
                    check($sformatf("v%0d period_valid", v), int'(period_valid), int'(vecs[v].exp_pv));
                    check($sformatf("v%0d overrun", v), int'(overrun), int'(vecs[v].exp_ovr));
                end
                if (i == 3)
                    check($sformatf("v%0d pulse_low", v), int'(pulse), 0);
            end
        end
    endtask

    initial begin
        //            en    ack   tog   gap  pulse cnt  wrap  period pv    ovr
        // steady decode, toggle every 4
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd1, 1'b0, 8'd0,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd2, 1'b0, 8'd4,  1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd3, 1'b0, 8'd4,  1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd4, 1'b0, 8'd4,  1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd5, 1'b0, 8'd4,  1'b1, 1'b0};
        // disabled toggles, then re-enable with 6-cycle spacing
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 4,   1'b0, 4'd5, 1'b0, 8'd4,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4,   1'b0, 4'd5, 1'b0, 8'd4,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4,   1'b0, 4'd5, 1'b0, 8'd4,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 6,   1'b1, 4'd6, 1'b0, 8'd4,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 6,   1'b1, 4'd7, 1'b0, 8'd6,  1'b1, 1'b0};
        // leaves an unacked measurement for the simultaneous ack/emit sequence
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4,   1'b1, 4'd8, 1'b0, 8'd6,  1'b1, 1'b0};
        // backpressure from IDLE: arm, measure 4, drop 5
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4,   1'b0, 4'd9, 1'b0, 8'd4,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 4,   1'b1, 4'd10, 1'b0, 8'd4, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 5,   1'b1, 4'd11, 1'b0, 8'd4, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 4,   1'b1, 4'd12, 1'b0, 8'd4, 1'b1, 1'b1};
        // wrap, then a 300-cycle gap
        vecs[15] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd13, 1'b0, 8'd5, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd14, 1'b0, 8'd4, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd15, 1'b0, 8'd4, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd0,  1'b1, 8'd4, 1'b1, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 300, 1'b1, 4'd1,  1'b1, 8'd4, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd2,  1'b1, 8'd255, 1'b1, 1'b1};
        // after mid-measurement reset: first toggle arms only
        vecs[21] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd1,  1'b0, 8'd0, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 4,   1'b1, 4'd2,  1'b0, 8'd4, 1'b1, 1'b0};

        rst        = 1'b1;
        enable     = 1'b1;
        t_in       = 1'b0;
        period_ack = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        check("rst pulse", int'(pulse), 0);
        check("rst count", int'(count), 0);
        check("rst count_wrap", int'(count_wrap), 0);
        check("rst period", int'(period), 0);
        check("rst period_valid", int'(period_valid), 0);
        check("rst overrun", int'(overrun), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post-rst pulse c%0d", i), int'(pulse), 0);
        end

        run_vecs(0, 10);

        // ack lands on the same edge as a new measurement: replace, no overrun
        period_ack = 1'b0;
        t_in       = ~t_in;
        step();
        step();
        period_ack = 1'b1;
        step();
        check("simul pulse", int'(pulse), 1);
        check("simul count", int'(count), 9);
        check("simul period", int'(period), 4);
        check("simul period_valid", int'(period_valid), 1);
        check("simul overrun", int'(overrun), 0);
        step();
        period_ack = 1'b0;
        check("simul ack clears valid", int'(period_valid), 0);
        check("simul pulse_low", int'(pulse), 0);

        run_vecs(11, 14);

        // single-cycle ack releases the held measurement; overrun stays sticky
        period_ack = 1'b1;
        step();
        period_ack = 1'b0;
        check("bp ack period_valid", int'(period_valid), 0);
        check("bp ack period", int'(period), 4);
        check("bp ack overrun", int'(overrun), 1);

        run_vecs(15, 20);

        // reset lands on the same edge as a pending accepted transition
        t_in = ~t_in;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst pulse", int'(pulse), 0);
        check("midrst count", int'(count), 0);
        check("midrst count_wrap", int'(count_wrap), 0);
        check("midrst period", int'(period), 0);
        check("midrst period_valid", int'(period_valid), 0);
        check("midrst overrun", int'(overrun), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midrst quiet pulse c%0d", i), int'(pulse), 0);
        end

        run_vecs(21, 22);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
